// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: fetch, data-memory and shared-bus signals of the arbiter.
// The master modport is the arbiter's view, slave is its environment's.
interface bus_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        err_o;
    logic        stall_req_o;

    modport master (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
        input  bus_rdata_i, bus_ack_i,
        output if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o,
        output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output err_o, stall_req_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
        output bus_rdata_i, bus_ack_i,
        input  if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o,
        input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  err_o, stall_req_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between instruction fetch and data
// memory with alternating priority and a per-transfer wait timeout.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

    state_t      state_q, state_d;
    logic        last_dm_q;
    logic [7:0]  cnt_q;
    logic        breq_q, bwe_q;
    logic [3:0]  bsel_q;
    logic [31:0] baddr_q, bwdata_q;
    logic        if_ack_q, dm_ack_q, err_q;
    logic [31:0] if_rd_q, dm_rd_q;
    logic        if_vld, dm_vld;
    logic        gnt_if, gnt_dm, done_ack, done_to;

    // a requester being acked this cycle is not re-arbitrated
    assign if_vld = bus.if_req_i & ~if_ack_q;
    assign dm_vld = bus.dm_req_i & ~dm_ack_q;

    always_comb begin
        state_d  = state_q;
        gnt_if   = 1'b0;
        gnt_dm   = 1'b0;
        done_ack = 1'b0;
        done_to  = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_dm = dm_vld & (~if_vld | ~last_dm_q);
                gnt_if = if_vld & ~gnt_dm;
                if (gnt_dm)      state_d = DM_BUSY;
                else if (gnt_if) state_d = IF_BUSY;
            end
            IF_BUSY, DM_BUSY: begin
                done_ack = bus.bus_ack_i;
                done_to  = ~bus.bus_ack_i & (cnt_q == 8'(TIMEOUT - 1));
                if (done_ack | done_to) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_dm_q <= 1'b0;
            cnt_q     <= '0;
            breq_q    <= 1'b0;
            bwe_q     <= 1'b0;
            bsel_q    <= '0;
            baddr_q   <= '0;
            bwdata_q  <= '0;
            if_ack_q  <= 1'b0;
            dm_ack_q  <= 1'b0;
            err_q     <= 1'b0;
            if_rd_q   <= '0;
            dm_rd_q   <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            err_q    <= 1'b0;
            if (gnt_if) begin
                breq_q    <= 1'b1;
                bwe_q     <= 1'b0;
                bsel_q    <= 4'hF;
                baddr_q   <= bus.if_addr_i;
                bwdata_q  <= '0;
                last_dm_q <= 1'b0;
                cnt_q     <= '0;
            end else if (gnt_dm) begin
                breq_q    <= 1'b1;
                bwe_q     <= bus.dm_we_i;
                bsel_q    <= bus.dm_sel_i;
                baddr_q   <= bus.dm_addr_i;
                bwdata_q  <= bus.dm_wdata_i;
                last_dm_q <= 1'b1;
                cnt_q     <= '0;
            end else if (done_ack | done_to) begin
                breq_q <= 1'b0;
                err_q  <= done_to;
                if (state_q == IF_BUSY) begin
                    if_ack_q <= 1'b1;
                    if_rd_q  <= done_ack ? bus.bus_rdata_i : 32'h0;
                end else begin
                    dm_ack_q <= 1'b1;
                    dm_rd_q  <= (done_ack & ~bwe_q) ? bus.bus_rdata_i : 32'h0;
                end
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign bus.bus_req_o   = breq_q;
    assign bus.bus_we_o    = bwe_q;
    assign bus.bus_sel_o   = bsel_q;
    assign bus.bus_addr_o  = baddr_q;
    assign bus.bus_wdata_o = bwdata_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.if_rdata_o  = if_rd_q;
    assign bus.dm_ack_o    = dm_ack_q;
    assign bus.dm_rdata_o  = dm_rd_q;
    assign bus.err_o       = err_q;
    // forced low during reset so every output is quiet
    assign bus.stall_req_o = rst & (if_vld | dm_vld);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbiter.
module tb_bus_arbiter;

    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bus_arbiter_if bif();

    bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bif.if_req_i    = 1'b0;
        bif.if_addr_i   = '0;
        bif.dm_req_i    = 1'b0;
        bif.dm_we_i     = 1'b0;
        bif.dm_sel_i    = '0;
        bif.dm_addr_i   = '0;
        bif.dm_wdata_i  = '0;
        bif.bus_rdata_i = '0;
        bif.bus_ack_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // reference model and agent state
    bit          m_busy, m_dm, m_last_dm, m_we, m_fin, m_to;
    bit          w_if, w_dm;
    int          m_wait;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wdata;
    bit          e_if_ack, e_dm_ack, e_err;
    logic [31:0] e_if_rd, e_dm_rd;
    int          s_cnt, s_lat;

    // directed-test scratch
    int hi, dm_seen, if_done, n_gnt, dm_ack_cyc, if_gnt_cyc;
    bit seen, prev_breq, if_gnt;
    bit owners[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        clr_inputs();

        // reset state, with a fetch request already waiting
        rst = 1'b0;
        bif.if_req_i  = 1'b1;
        bif.if_addr_i = 32'h0000_0400;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_breq", 32'(bif.bus_req_o), 0);
        chk("rst_if_ack", 32'(bif.if_ack_o), 0);
        chk("rst_dm_ack", 32'(bif.dm_ack_o), 0);
        chk("rst_err", 32'(bif.err_o), 0);
        chk("rst_stall", 32'(bif.stall_req_o), 0);
        chk("rst_sel", 32'(bif.bus_sel_o), 0);
        chk("rst_addr", bif.bus_addr_o, 0);
        chk("rst_if_rd", bif.if_rdata_o, 0);
        chk("rst_dm_rd", bif.dm_rdata_o, 0);
        rst = 1'b1;
        #1;
        chk("if_stall", 32'(bif.stall_req_o), 1);

        // IF read, slave acks one cycle after bus_req
        tick();
        chk("if_gnt_breq", 32'(bif.bus_req_o), 1);
        chk("if_gnt_we", 32'(bif.bus_we_o), 0);
        chk("if_gnt_sel", 32'(bif.bus_sel_o), 32'hF);
        chk("if_gnt_addr", bif.bus_addr_o, 32'h0000_0400);
        tick();
        chk("if_wait_breq", 32'(bif.bus_req_o), 1);
        chk("if_wait_we", 32'(bif.bus_we_o), 0);
        chk("if_wait_ack", 32'(bif.if_ack_o), 0);
        bif.bus_ack_i   = 1'b1;
        bif.bus_rdata_i = 32'h3C01_0010;
        tick();
        chk("if_ack", 32'(bif.if_ack_o), 1);
        chk("if_rdata", bif.if_rdata_o, 32'h3C01_0010);
        chk("if_err", 32'(bif.err_o), 0);
        chk("if_done_breq", 32'(bif.bus_req_o), 0);
        chk("if_ack_stall", 32'(bif.stall_req_o), 0);
        bif.bus_ack_i   = 1'b0;
        bif.bus_rdata_i = 32'h5555_AAAA;
        bif.if_req_i    = 1'b0;
        tick();
        chk("if_ack_pulse", 32'(bif.if_ack_o), 0);
        chk("if_rd_hold", bif.if_rdata_o, 32'h3C01_0010);

        // DM write with a zero-wait slave
        bif.dm_req_i   = 1'b1;
        bif.dm_we_i    = 1'b1;
        bif.dm_sel_i   = 4'b0011;
        bif.dm_addr_i  = 32'h0000_0100;
        bif.dm_wdata_i = 32'hDEAD_BEEF;
        #1;
        chk("dm_stall", 32'(bif.stall_req_o), 1);
        tick();
        chk("dm_breq", 32'(bif.bus_req_o), 1);
        chk("dm_we", 32'(bif.bus_we_o), 1);
        chk("dm_sel", 32'(bif.bus_sel_o), 32'h3);
        chk("dm_addr", bif.bus_addr_o, 32'h0000_0100);
        chk("dm_wdata", bif.bus_wdata_o, 32'hDEAD_BEEF);
        bif.bus_ack_i   = 1'b1;
        bif.bus_rdata_i = 32'h1234_5678;
        tick();
        chk("dm_ack", 32'(bif.dm_ack_o), 1);
        chk("dm_rdata", bif.dm_rdata_o, 0);
        chk("dm_err", 32'(bif.err_o), 0);
        chk("dm_done_breq", 32'(bif.bus_req_o), 0);
        bif.dm_req_i  = 1'b0;
        bif.bus_ack_i = 1'b0;

        // IF read against a slave that never answers
        bif.if_req_i  = 1'b1;
        bif.if_addr_i = 32'h0000_0800;
        hi   = 0;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (bif.bus_req_o) hi++;
            if (bif.if_ack_o) begin
                seen = 1'b1;
                chk("to_err", 32'(bif.err_o), 1);
                chk("to_rdata", bif.if_rdata_o, 0);
                chk("to_breq", 32'(bif.bus_req_o), 0);
            end
        end
        chk("to_seen", 32'(seen), 1);
        chk("to_cycles", hi, TIMEOUT);
        bif.if_req_i = 1'b0;
        tick();
        chk("to_err_pulse", 32'(bif.err_o), 0);

        // simultaneous requests alternate, DM first after reset
        do_reset();
        bif.if_req_i  = 1'b1;
        bif.if_addr_i = 32'h0000_1000;
        bif.dm_req_i  = 1'b1;
        bif.dm_sel_i  = 4'hF;
        bif.dm_addr_i = 32'h0000_2000;
        n_gnt      = 0;
        dm_ack_cyc = -1;
        if_gnt_cyc = -1;
        prev_breq  = 1'b0;
        for (int c = 0; c < 40 && n_gnt < 4; c++) begin
            tick();
            if (bif.bus_req_o && !prev_breq) begin
                owners[n_gnt] = (bif.bus_addr_o == 32'h0000_2000);
                if (n_gnt == 1) if_gnt_cyc = c;
                n_gnt++;
            end
            if (bif.dm_ack_o && dm_ack_cyc < 0) dm_ack_cyc = c;
            bif.bus_ack_i = bif.bus_req_o && prev_breq;
            prev_breq     = bif.bus_req_o;
        end
        chk("arb_grants", n_gnt, 4);
        chk("arb_order0", 32'(owners[0]), 1);
        chk("arb_order1", 32'(owners[1]), 0);
        chk("arb_order2", 32'(owners[2]), 1);
        chk("arb_order3", 32'(owners[3]), 0);
        chk("arb_if_in_dm_ack", if_gnt_cyc, dm_ack_cyc + 1);
        bif.if_req_i = 1'b0;
        bif.dm_req_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            bif.bus_ack_i = bif.bus_req_o && prev_breq;
            prev_breq     = bif.bus_req_o;
        end

        // reset two cycles into a DM transfer
        bif.bus_ack_i = 1'b0;
        bif.dm_req_i  = 1'b1;
        bif.dm_we_i   = 1'b0;
        bif.dm_sel_i  = 4'hF;
        bif.dm_addr_i = 32'h0000_0300;
        tick();
        chk("mid_breq", 32'(bif.bus_req_o), 1);
        tick();
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_breq", 32'(bif.bus_req_o), 0);
        chk("mid_rst_dm_ack", 32'(bif.dm_ack_o), 0);
        chk("mid_rst_err", 32'(bif.err_o), 0);
        chk("mid_rst_stall", 32'(bif.stall_req_o), 0);
        chk("mid_rst_addr", bif.bus_addr_o, 0);
        bif.dm_req_i  = 1'b0;
        bif.if_req_i  = 1'b1;
        bif.if_addr_i = 32'h0000_0500;
        @(posedge clk);
        #1;
        rst = 1'b1;
        dm_seen   = 0;
        if_done   = 0;
        if_gnt    = 1'b0;
        prev_breq = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bif.dm_ack_o) dm_seen++;
            if (bif.bus_req_o && bif.bus_addr_o == 32'h0000_0500) if_gnt = 1'b1;
            if (bif.if_ack_o) begin
                if_done++;
                bif.if_req_i = 1'b0;
            end
            bif.bus_ack_i = bif.bus_req_o && prev_breq;
            prev_breq     = bif.bus_req_o;
        end
        chk("mid_no_dm_ack", dm_seen, 0);
        chk("mid_if_gnt", 32'(if_gnt), 1);
        chk("mid_if_ack", if_done, 1);

        // randomized traffic against the reference model
        do_reset();
        m_busy    = 1'b0;
        m_last_dm = 1'b0;
        m_wait    = 0;
        e_if_ack  = 1'b0;
        e_dm_ack  = 1'b0;
        e_err     = 1'b0;
        e_if_rd   = '0;
        e_dm_rd   = '0;
        s_cnt     = 0;
        s_lat     = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            chk("r_if_ack", 32'(bif.if_ack_o), 32'(e_if_ack));
            chk("r_dm_ack", 32'(bif.dm_ack_o), 32'(e_dm_ack));
            chk("r_err", 32'(bif.err_o), 32'(e_err));
            chk("r_if_rd", bif.if_rdata_o, e_if_rd);
            chk("r_dm_rd", bif.dm_rdata_o, e_dm_rd);
            chk("r_breq", 32'(bif.bus_req_o), 32'(m_busy));
            if (m_busy) begin
                chk("r_addr", bif.bus_addr_o, m_addr);
                chk("r_we", 32'(bif.bus_we_o), 32'(m_we));
                chk("r_sel", 32'(bif.bus_sel_o), 32'(m_sel));
                if (m_we) chk("r_wdata", bif.bus_wdata_o, m_wdata);
            end

            // masters: back-to-back, abandon mid-transfer, or idle
            if (bif.if_ack_o) begin
                bif.if_req_i = ($urandom_range(0, 1) == 1);
                bif.if_addr_i = $urandom;
            end else if (bif.if_req_i) begin
                if ($urandom_range(0, 19) == 0) bif.if_req_i = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                bif.if_req_i  = 1'b1;
                bif.if_addr_i = $urandom;
            end
            if (bif.dm_ack_o || (!bif.dm_req_i && $urandom_range(0, 2) == 0)) begin
                bif.dm_req_i   = bif.dm_ack_o ? ($urandom_range(0, 1) == 1) : 1'b1;
                bif.dm_we_i    = $urandom_range(0, 1) == 1;
                bif.dm_sel_i   = 4'($urandom);
                bif.dm_addr_i  = $urandom;
                bif.dm_wdata_i = $urandom;
            end else if (bif.dm_req_i && $urandom_range(0, 19) == 0) begin
                bif.dm_req_i = 1'b0;
            end

            // slave: latency 0..6 after bus_req rises, stray acks while idle
            if (bif.bus_req_o) begin
                if (s_cnt == 0) s_lat = $urandom_range(0, 6);
                bif.bus_ack_i = (s_cnt == s_lat);
                s_cnt++;
            end else begin
                s_cnt = 0;
                bif.bus_ack_i = ($urandom_range(0, 9) == 0);
            end
            bif.bus_rdata_i = $urandom;
            #1;
            chk("r_stall", 32'(bif.stall_req_o),
                32'((bif.if_req_i & ~bif.if_ack_o) | (bif.dm_req_i & ~bif.dm_ack_o)));

            // what the next edge must produce
            e_if_ack = 1'b0;
            e_dm_ack = 1'b0;
            e_err    = 1'b0;
            if (m_busy) begin
                m_fin = 1'b0;
                m_to  = 1'b0;
                if (bif.bus_ack_i) begin
                    m_fin = 1'b1;
                end else if (m_wait + 1 == TIMEOUT) begin
                    m_fin = 1'b1;
                    m_to  = 1'b1;
                end else begin
                    m_wait++;
                end
                if (m_fin) begin
                    m_busy = 1'b0;
                    e_err  = m_to;
                    if (m_dm) begin
                        e_dm_ack = 1'b1;
                        e_dm_rd  = (m_to || m_we) ? 32'h0 : bif.bus_rdata_i;
                    end else begin
                        e_if_ack = 1'b1;
                        e_if_rd  = m_to ? 32'h0 : bif.bus_rdata_i;
                    end
                end
            end else begin
                w_if = bif.if_req_i && !bif.if_ack_o;
                w_dm = bif.dm_req_i && !bif.dm_ack_o;
                if (w_if || w_dm) begin
                    m_dm      = (w_if && w_dm) ? !m_last_dm : w_dm;
                    m_last_dm = m_dm;
                    m_busy    = 1'b1;
                    m_wait    = 0;
                    m_addr    = m_dm ? bif.dm_addr_i : bif.if_addr_i;
                    m_we      = m_dm ? bif.dm_we_i : 1'b0;
                    m_sel     = m_dm ? bif.dm_sel_i : 4'hF;
                    m_wdata   = bif.dm_wdata_i;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
